traffic_lamp_driver: RTL and testbench

Output stage directly downstream of the four-way traffic controller. Consumes the four 3-bit direction codes (001 green, 010 yellow, 100 red) and drives the physical lamps with PWM dimming. Checks every sample for illegal or conflicting codes. On a persistent error it latches a safe flashing-red mode until software clears it.

---
 rtl/traffic_lamp_driver.sv | 173 +++++++++++++++++
 tb/tb_traffic_lamp_driver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_lamp_driver.sv
// traffic_lamp_driver: registers the four direction codes, screens them for illegal/conflicting
// values and drives the lamps, falling back to a latched flashing-red FAULT. Define LAMP_PWM_EN for PWM dimming.
module traffic_lamp_driver #(
  parameter int PWM_BITS     = 8,
  parameter int BLINK_DIV    = 16,
  parameter int FAULT_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          north_dir,
  input  logic [2:0]          south_dir,
  input  logic [2:0]          east_dir,
  input  logic [2:0]          west_dir,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                fault_clr,
  output logic [2:0]          led_north,
  output logic [2:0]          led_south,
  output logic [2:0]          led_east,
  output logic [2:0]          led_west,
  output logic                fault,
  output logic [1:0]          fault_cause
);

  // state      | meaning
  // ST_NORMAL  | codes clean, registered codes displayed
  // ST_SUSPECT | error seen, holding last_good while counting error samples
  // ST_FAULT   | latched flashing red until fault_clr with clean codes
  typedef enum logic [1:0] {ST_NORMAL, ST_SUSPECT, ST_FAULT} state_t;

  localparam int CW = (FAULT_CYCLES > 1) ? $clog2(FAULT_CYCLES + 1) : 1;
  localparam int BW = $clog2(BLINK_DIV);

  state_t          state_q, state_d;
  logic [3:0][2:0] dir_q, dir_d, last_good_q, last_good_d, led_q, led_d, disp;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [BW-1:0]   blink_q, blink_d;
  logic            phase_q, phase_d;
  logic [1:0]      cause_q, cause_d;
  logic            illegal, conflict, err, pwm_on;
  logic [2:0]      n_active;

  assign dir_d = {west_dir, east_dir, south_dir, north_dir};

  always_comb begin
    illegal  = 1'b0;
    n_active = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!(dir_q[i] inside {3'b001, 3'b010, 3'b100})) illegal = 1'b1;
      if (dir_q[i] != 3'b100) n_active = n_active + 3'd1;
    end
    conflict = (n_active > 3'd1);
    err      = illegal | conflict;
  end

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cause_d     = cause_q;
    blink_d     = blink_q;
    phase_d     = phase_q;
    last_good_d = last_good_q;
    case (state_q)
      ST_NORMAL: begin
        if (!err) begin
          last_good_d = dir_q;
        end else if (FAULT_CYCLES == 1) begin
          state_d = ST_FAULT;
          cause_d = {conflict, illegal};
          blink_d = '0;
          phase_d = 1'b1;
        end else begin
          state_d = ST_SUSPECT;
          cnt_d   = CW'(1);
        end
      end
      ST_SUSPECT: begin
        if (!err) begin
          state_d = ST_NORMAL;
          cnt_d   = '0;
        end else if (cnt_inc == CW'(FAULT_CYCLES)) begin
          state_d = ST_FAULT;
          cnt_d   = '0;
          cause_d = {conflict, illegal};
          blink_d = '0;
          phase_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_FAULT: begin
        if (blink_q == BW'(BLINK_DIV - 1)) begin
          blink_d = '0;
          phase_d = ~phase_q;
        end else begin
          blink_d = blink_q + BW'(1);
        end
        if (fault_clr && !err) begin
          state_d = ST_NORMAL;
          cause_d = 2'b00;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // A raw sample is only trusted when it is clean; otherwise show the last clean frame.
  always_comb begin
    disp = last_good_q;
    if (state_q == ST_NORMAL && !err) disp = dir_q;
    for (int i = 0; i < 4; i++) begin
      led_d[i] = disp[i] & {3{pwm_on}};
      if (state_q == ST_FAULT) led_d[i] = phase_q ? 3'b100 : 3'b000;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_NORMAL;
      dir_q       <= {4{3'b100}};
      last_good_q <= {4{3'b100}};
      cnt_q       <= '0;
      cause_q     <= 2'b00;
      blink_q     <= '0;
      phase_q     <= 1'b1;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      last_good_q <= last_good_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      blink_q     <= blink_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
    end
  end

`ifdef LAMP_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;

  // Duty only reloads at the wrap so a period is never cut short.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    duty_d    = (pwm_cnt_q == '0) ? brightness : duty_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
    end
  end

  assign pwm_on = (&duty_q) | (pwm_cnt_q < duty_q);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pwm_on            = 1'b1;
`endif

  assign led_north   = led_q[0];
  assign led_south   = led_q[1];
  assign led_east    = led_q[2];
  assign led_west    = led_q[3];
  assign fault       = (state_q == ST_FAULT);
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Directed bench for traffic_lamp_driver with default parameters (FAULT_CYCLES 3, BLINK_DIV 16).
module tb_traffic_lamp_driver;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] north_dir, south_dir, east_dir, west_dir;
  logic [7:0] brightness;
  logic       fault_clr;
  logic [2:0] led_north, led_south, led_east, led_west;
  logic       fault;
  logic [1:0] fault_cause;

  int checks = 0;
  int errors = 0;

  traffic_lamp_driver dut (
    .clk(clk), .reset(reset),
    .north_dir(north_dir), .south_dir(south_dir), .east_dir(east_dir), .west_dir(west_dir),
    .brightness(brightness), .fault_clr(fault_clr),
    .led_north(led_north), .led_south(led_south), .led_east(led_east), .led_west(led_west),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_red();
    north_dir = 3'b100; south_dir = 3'b100; east_dir = 3'b100; west_dir = 3'b100;
  endtask

  task automatic test_reset();
    reset = 1'b1; all_red(); brightness = 8'hFF; fault_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({led_west, led_east, led_south, led_north} !== 12'h000) begin
      errors++; $display("FAIL reset_led got=%h exp=000", {led_west, led_east, led_south, led_north});
    end
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++;
    if (fault_cause !== 2'b00) begin errors++; $display("FAIL reset_cause got=%b exp=00", fault_cause); end
    reset = 1'b0;
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({led_west, led_east, led_south, led_north} !== {4{3'b100}}) begin
        errors++; $display("FAIL steady_red cyc=%0d got=%h exp=924", k, {led_west, led_east, led_south, led_north});
      end
      tick();
    end
  endtask

  task automatic test_legal();
    north_dir = 3'b001;
    tick();
    checks++;
    if (led_north !== 3'b100) begin errors++; $display("FAIL legal_latency got=%b exp=100", led_north); end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (led_north !== 3'b001 || fault !== 1'b0) begin
        errors++; $display("FAIL legal_green cyc=%0d led=%b fault=%b exp=001/0", k, led_north, fault);
      end
    end
    north_dir = 3'b010;
    tick();
    checks++;
    if (led_north !== 3'b001) begin errors++; $display("FAIL legal_hold got=%b exp=001", led_north); end
    tick();
    checks++;
    if (led_north !== 3'b010 || led_east !== 3'b100) begin
      errors++; $display("FAIL legal_yellow n=%b e=%b exp=010/100", led_north, led_east);
    end
  endtask

  task automatic test_transient_conflict();
    logic [2:0] exp_n;
    north_dir = 3'b001;
    repeat (3) tick();
    east_dir = 3'b001;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 1) begin east_dir = 3'b100; north_dir = 3'b010; end
      exp_n = (k == 4) ? 3'b010 : 3'b001;
      checks++;
      if (led_north !== exp_n || led_east !== 3'b100 || fault !== 1'b0) begin
        errors++;
        $display("FAIL transient cyc=%0d n=%b e=%b fault=%b exp n=%b e=100 f=0", k, led_north, led_east, fault, exp_n);
      end
    end
  endtask

  task automatic test_persistent_illegal();
    logic [2:0] exp_l;
    all_red();
    repeat (3) tick();
    south_dir = 3'b011;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (fault !== 1'b0) begin errors++; $display("FAIL illegal_early cyc=%0d fault=%b exp=0", k, fault); end
    end
    tick();
    checks++;
    if (fault !== 1'b1 || fault_cause !== 2'b01) begin
      errors++; $display("FAIL illegal_entry fault=%b cause=%b exp=1/01", fault, fault_cause);
    end
    for (int k = 4; k < 52; k++) begin
      tick();
      exp_l = ((((k - 4) / 16) % 2) == 0) ? 3'b100 : 3'b000;
      checks++;
      if ({led_west, led_east, led_south, led_north} !== {4{exp_l}}) begin
        errors++; $display("FAIL blink edge=%0d got=%h exp_each=%b", k, {led_west, led_east, led_south, led_north}, exp_l);
      end
    end
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b1 || fault_cause !== 2'b01) begin
      errors++; $display("FAIL clr_ignored fault=%b cause=%b exp=1/01", fault, fault_cause);
    end
    south_dir = 3'b100; north_dir = 3'b001;
    tick();
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b0 || fault_cause !== 2'b00) begin
      errors++; $display("FAIL clr_exit fault=%b cause=%b exp=0/00", fault, fault_cause);
    end
    tick();
    checks++;
    if (led_north !== 3'b001 || led_south !== 3'b100) begin
      errors++; $display("FAIL resume n=%b s=%b exp=001/100", led_north, led_south);
    end
  endtask

  task automatic test_dual_cause();
    north_dir = 3'b111; east_dir = 3'b001;
    repeat (3) tick();
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL dual_early fault=%b exp=0", fault); end
    tick();
    checks++;
    if (fault !== 1'b1 || fault_cause !== 2'b11) begin
      errors++; $display("FAIL dual_cause fault=%b cause=%b exp=1/11", fault, fault_cause);
    end
    all_red();
    tick();
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b0 || fault_cause !== 2'b00) begin
      errors++; $display("FAIL dual_clear fault=%b cause=%b exp=0/00", fault, fault_cause);
    end
  endtask

  task automatic test_async_reset();
    all_red();
    repeat (2) tick();
    south_dir = 3'b011;
    repeat (5) tick();
    checks++;
    if (fault !== 1'b1 || led_north !== 3'b100) begin
      errors++; $display("FAIL pre_reset fault=%b n=%b exp=1/100", fault, led_north);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({led_west, led_east, led_south, led_north} !== 12'h000 || fault !== 1'b0 || fault_cause !== 2'b00) begin
      errors++;
      $display("FAIL async_reset led=%h fault=%b cause=%b exp=000/0/00", {led_west, led_east, led_south, led_north}, fault, fault_cause);
    end
    all_red();
  endtask

`ifdef LAMP_PWM_EN
  task automatic test_pwm();
    int on1, on2;
    on1 = 0; on2 = 0;
    brightness = 8'd64;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k <= 512; k++) begin
      tick();
      if (k == 100) brightness = 8'd128;
      if (k >= 1 && k <= 256) on1 += int'(led_north[2]);
      else if (k >= 257) on2 += int'(led_north[2]);
      if (k == 150) begin
        checks++;
        if (led_west[2] !== 1'b0) begin errors++; $display("FAIL pwm_midperiod got=%b exp=0", led_west[2]); end
      end
    end
    checks++;
    if (on1 != 64) begin errors++; $display("FAIL pwm_duty64 got=%0d exp=64", on1); end
    checks++;
    if (on2 != 128) begin errors++; $display("FAIL pwm_duty128 got=%0d exp=128", on2); end
  endtask
`else
  task automatic test_pwm_disabled();
    brightness = 8'd0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({led_west, led_east, led_south, led_north} !== {4{3'b100}}) begin
        errors++; $display("FAIL nopwm cyc=%0d got=%h exp=924", k, {led_west, led_east, led_south, led_north});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_legal();
    test_transient_conflict();
    test_persistent_illegal();
    test_dual_cause();
    test_async_reset();
`ifdef LAMP_PWM_EN
    test_pwm();
`else
    test_pwm_disabled();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
